// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clint_pkg
// Description : Shared definitions for the core-local interruptor.
//               Holds the 64-bit time width, the register byte offsets of the
//               CLINT window and the decoded register-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package clint_pkg;

    // Width of mtime / mtimecmp
    localparam int CLINT_TIME_WIDTH = 64;

    // Register byte offsets inside the CLINT window
    localparam logic [15:0] CLINT_MSIP_ADDR        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_ADDR = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_ADDR = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_ADDR    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_ADDR    = 16'hBFFC;

    // Register selected by the current bus address
    typedef enum logic [2:0] {
        REG_NONE        = 3'd0,
        REG_MSIP        = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_MTIME_LO    = 3'd4,
        REG_MTIME_HI    = 3'd5
    } clint_reg_e;

endpackage
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// ============================================================================
// Module      : mtime_counter
// Description : 64-bit free-running machine timer with half-word write
//               replacement and an optional tick prescaler.
//               Optional feature macro: CLINT_MTIME_PRESCALE_EN
//                 defined   -> 16-bit prescaler, one tick every PRESCALE cycles
//                 undefined -> mtime increments every cycle
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_wen_lo/hi   - replace low/high half of mtime with i_wdata
//               i_wdata       - write data
//               o_mtime       - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module mtime_counter
    import clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wen_lo,
    input  logic                        i_wen_hi,
    input  logic [31:0]                 i_wdata,
    output logic [CLINT_TIME_WIDTH-1:0] o_mtime
);

    logic [CLINT_TIME_WIDTH-1:0] r_mtime;
    logic                        w_tick;
    logic                        w_wr;

    assign w_wr = i_wen_lo | i_wen_hi;

`ifdef CLINT_MTIME_PRESCALE_EN
    localparam logic [15:0] c_pre_last = 16'(PRESCALE - 1);

    logic [15:0] r_pre;

    assign w_tick = (r_pre == c_pre_last);

    // A write to mtime restarts the tick phase so the new value holds for a
    // full PRESCALE period before its first increment.
    always_ff @(posedge clk) begin
        if (rst || w_wr) begin
            r_pre <= 16'd0;
        end else if (w_tick) begin
            r_pre <= 16'd0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end
`else
    logic [15:0] w_unused_prescale;

    assign w_unused_prescale = 16'(PRESCALE);
    assign w_tick            = 1'b1;
`endif

    // Writes win over the increment: no carry into the unwritten half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime <= '0;
        end else if (w_wr) begin
            if (i_wen_lo) begin
                r_mtime[31:0] <= i_wdata;
            end
            if (i_wen_hi) begin
                r_mtime[63:32] <= i_wdata;
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    assign o_mtime = r_mtime;

endmodule
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module      : clint
// Description : Core-local interruptor. Memory-mapped msip / mtimecmp / mtime
//               registers on a single-cycle peripheral port, driving the
//               software and timer interrupt levels.
//               Optional feature macro: CLINT_MTIME_PRESCALE_EN (mtime
//               prescaler inside mtime_counter, divisor PRESCALE).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               clint_wen/ren       - write / read strobes
//               clint_addr          - byte address, bits [1:0] ignored
//               clint_wdata         - write data (full word)
//               clint_rdata/rvalid  - read data, valid one cycle after ren
//               software_interrupt  - msip[0]
//               timer_interrupt     - registered mtime >= mtimecmp
// Revision    : 1.0 - initial release
// ============================================================================
module clint
    import clint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clint_wen,
    input  logic              clint_ren,
    input  logic [ADDR_W-1:0] clint_addr,
    input  logic [31:0]       clint_wdata,
    output logic [31:0]       clint_rdata,
    output logic              clint_rvalid,
    output logic              software_interrupt,
    output logic              timer_interrupt
);

    localparam logic [ADDR_W-1:0] c_msip_addr   = ADDR_W'(CLINT_MSIP_ADDR);
    localparam logic [ADDR_W-1:0] c_cmp_lo_addr = ADDR_W'(CLINT_MTIMECMP_LO_ADDR);
    localparam logic [ADDR_W-1:0] c_cmp_hi_addr = ADDR_W'(CLINT_MTIMECMP_HI_ADDR);
    localparam logic [ADDR_W-1:0] c_mt_lo_addr  = ADDR_W'(CLINT_MTIME_LO_ADDR);
    localparam logic [ADDR_W-1:0] c_mt_hi_addr  = ADDR_W'(CLINT_MTIME_HI_ADDR);

    logic [ADDR_W-3:0]           w_word;
    logic [1:0]                  w_unused_addr_lsb;
    clint_reg_e                  w_sel;
    logic [31:0]                 w_rd_mux;
    logic [CLINT_TIME_WIDTH-1:0] w_mtime;

    logic                        r_msip;
    logic [CLINT_TIME_WIDTH-1:0] r_mtimecmp;
    logic [31:0]                 r_rdata;
    logic                        r_rvalid;
    logic                        r_timer;

    // Word-granular decode; the byte lane bits carry no meaning.
    assign w_word            = clint_addr[ADDR_W-1:2];
    assign w_unused_addr_lsb = clint_addr[1:0];

    always_comb begin
        w_sel = REG_NONE;
        if (w_word == c_msip_addr[ADDR_W-1:2]) begin
            w_sel = REG_MSIP;
        end else if (w_word == c_cmp_lo_addr[ADDR_W-1:2]) begin
            w_sel = REG_MTIMECMP_LO;
        end else if (w_word == c_cmp_hi_addr[ADDR_W-1:2]) begin
            w_sel = REG_MTIMECMP_HI;
        end else if (w_word == c_mt_lo_addr[ADDR_W-1:2]) begin
            w_sel = REG_MTIME_LO;
        end else if (w_word == c_mt_hi_addr[ADDR_W-1:2]) begin
            w_sel = REG_MTIME_HI;
        end
    end

    mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_mtime_counter (
        .clk      (clk),
        .rst      (rst),
        .i_wen_lo (clint_wen && (w_sel == REG_MTIME_LO)),
        .i_wen_hi (clint_wen && (w_sel == REG_MTIME_HI)),
        .i_wdata  (clint_wdata),
        .o_mtime  (w_mtime)
    );

    // Read mux sees pre-write register values, so a same-cycle write and
    // read to one register returns the old contents.
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_sel)
            REG_MSIP:        w_rd_mux = {31'd0, r_msip};
            REG_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
            REG_MTIME_LO:    w_rd_mux = w_mtime[31:0];
            REG_MTIME_HI:    w_rd_mux = w_mtime[63:32];
            default:         w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= '1;
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_timer    <= 1'b0;
        end else begin
            r_rvalid <= clint_ren;
            if (clint_ren) begin
                r_rdata <= w_rd_mux;
            end
            // Compare of the settled registers; transient matches during a
            // two-step mtimecmp update are intentionally not filtered.
            r_timer <= (w_mtime >= r_mtimecmp);
            if (clint_wen) begin
                case (w_sel)
                    REG_MSIP:        r_msip            <= clint_wdata[0];
                    REG_MTIMECMP_LO: r_mtimecmp[31:0]  <= clint_wdata;
                    REG_MTIMECMP_HI: r_mtimecmp[63:32] <= clint_wdata;
                    default:         ;
                endcase
            end
        end
    end

    assign clint_rdata        = r_rdata;
    assign clint_rvalid       = r_rvalid;
    assign software_interrupt = r_msip;
    assign timer_interrupt    = r_timer;

endmodule
`default_nettype wire
